// File: rtl/sat_pkg.sv
// Shared encodings for the DPLL search controller and the clause evaluator.
package sat_pkg;

    typedef enum logic [1:0] {
        VAL_FALSE   = 2'b00,
        VAL_TRUE    = 2'b01,
        VAL_UNKNOWN = 2'b10
    } val_t;

    typedef enum logic [1:0] {
        RES_UNSAT   = 2'b00,
        RES_SAT     = 2'b01,
        RES_UNKNOWN = 2'b10
    } res_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EVAL,
        ST_DECIDE,
        ST_BACKTRACK,
        ST_FINISH
    } state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/dpll_search_ctrl.sv
// Chronological-backtracking DPLL search over NUM_VARS variables; the clause
// evaluator outside this block turns the assignment into eval_result.
module dpll_search_ctrl
    import sat_pkg::*;
#(
    parameter int NUM_VARS   = 8,
    parameter int MAX_CYCLES = 65535
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            eval_result,
    output logic [NUM_VARS*2-1:0] assignment,
    output logic                  busy,
    output logic                  done,
    output logic                  sat,
    output logic                  timeout,
    output logic [31:0]           decisions
);

    localparam int LVL_W = $clog2(NUM_VARS + 1);
    localparam int IDX_W = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);

    state_t                  state, state_n;
    logic [LVL_W-1:0]        level, level_n;
    logic [NUM_VARS-1:0]     flipped, flipped_n;
    logic [NUM_VARS*2-1:0]   asg_n;
    logic [31:0]             dec_n;
    logic                    sat_n, timeout_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [IDX_W-1:0]        cur_idx, prev_idx;

    // level counts assigned variables, so the deepest assigned one is level-1
    assign cur_idx  = IDX_W'(level);
    assign prev_idx = IDX_W'(level - 1'b1);

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_FINISH);

    always_comb begin
        state_n   = state;
        asg_n     = assignment;
        level_n   = level;
        flipped_n = flipped;
        dec_n     = decisions;
        sat_n     = sat;
        timeout_n = timeout;
        cnt_n     = cnt;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    asg_n     = {NUM_VARS{VAL_UNKNOWN}};
                    level_n   = '0;
                    flipped_n = '0;
                    dec_n     = '0;
                    sat_n     = 1'b0;
                    timeout_n = 1'b0;
                    cnt_n     = '0;
                    state_n   = ST_EVAL;
                end
            end
            ST_FINISH: begin
                cnt_n   = cnt + 1'b1;
                state_n = ST_IDLE;
            end
            default: begin
                cnt_n = cnt + 1'b1;
                // the budget wins over whatever this cycle would otherwise do
                if (cnt == CNT_W'(MAX_CYCLES - 1)) begin
                    state_n   = ST_FINISH;
                    timeout_n = 1'b1;
                    sat_n     = 1'b0;
                end else begin
                    case (state)
                        ST_EVAL: begin
                            if (eval_result == RES_SAT) begin
                                sat_n   = 1'b1;
                                state_n = ST_FINISH;
                            end else if (eval_result == RES_UNSAT) begin
                                state_n = ST_BACKTRACK;
                            end else begin
                                state_n = ST_DECIDE;
                            end
                        end
                        ST_DECIDE: begin
                            // no verdict on a complete assignment is a conflict
                            if (level == LVL_W'(NUM_VARS)) begin
                                state_n = ST_BACKTRACK;
                            end else begin
                                asg_n[{cur_idx, 1'b0} +: 2] = VAL_FALSE;
                                flipped_n[cur_idx]          = 1'b0;
                                level_n                     = level + 1'b1;
                                dec_n                       = sat_inc32(decisions);
                                state_n                     = ST_EVAL;
                            end
                        end
                        ST_BACKTRACK: begin
                            if (level == '0) begin
                                sat_n   = 1'b0;
                                state_n = ST_FINISH;
                            end else if (!flipped[prev_idx]) begin
                                asg_n[{prev_idx, 1'b0} +: 2] = VAL_TRUE;
                                flipped_n[prev_idx]          = 1'b1;
                                dec_n                        = sat_inc32(decisions);
                                state_n                      = ST_EVAL;
                            end else begin
                                asg_n[{prev_idx, 1'b0} +: 2] = VAL_UNKNOWN;
                                level_n                      = level - 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            assignment <= {NUM_VARS{VAL_UNKNOWN}};
            level      <= '0;
            flipped    <= '0;
            decisions  <= '0;
            sat        <= 1'b0;
            timeout    <= 1'b0;
            cnt        <= '0;
        end else begin
            state      <= state_n;
            assignment <= asg_n;
            level      <= level_n;
            flipped    <= flipped_n;
            decisions  <= dec_n;
            sat        <= sat_n;
            timeout    <= timeout_n;
            cnt        <= cnt_n;
        end
    end

endmodule

// File: tb/tb_dpll_search_ctrl.sv
// Bench for dpll_search_ctrl: two instances (large and tiny cycle budget) against
// an abstract depth-first search model driven by a combinational clause model.
module tb_dpll_search_ctrl;
    import sat_pkg::*;

    localparam int NV     = 3;
    localparam int MAXB   = 10;
    localparam int BIG    = 65535;
    localparam int BUDGET = 400;
    localparam logic [5:0] ALL_U = 6'b101010;

    logic        clk = 1'b0;
    logic        rst, start_a, start_b;
    logic [1:0]  eval_a, eval_b;
    logic [5:0]  asg_a, asg_b;
    logic        busy_a, done_a, sat_a, to_a;
    logic        busy_b, done_b, sat_b, to_b;
    logic [31:0] dec_a, dec_b;

    int          mode;
    logic [11:0] cpos, cneg;
    int          ncl;

    int n_checks = 0;
    int n_err    = 0;

    logic        cs_a, ct_a, cs_b, ct_b;
    logic [5:0]  ca_a, ca_b;
    logic [31:0] cd_a, cd_b;
    int          ta, tb;

    always #5 clk = ~clk;

    // mode 0: CNF clauses; mode 1: always UNSAT; mode 2: UNKNOWN until full, then UNSAT
    function automatic logic [1:0] eval_fn(input int m, input logic [11:0] p, input logic [11:0] n,
                                           input int nc, input logic [5:0] a);
        bit all_sat, csat, cfalse, any_u;
        logic [1:0] fv;
        if (m == 1) return 2'b00;
        if (m == 2) begin
            any_u = 0;
            for (int k = 0; k < NV; k++) if (a[2*k +: 2] == 2'b10) any_u = 1;
            if (!any_u) return 2'b00;
            return (a[1:0] == 2'b01) ? 2'b11 : 2'b10;
        end
        all_sat = 1;
        for (int c = 0; c < nc; c++) begin
            csat = 0; cfalse = 1;
            for (int k = 0; k < NV; k++) begin
                fv = a[2*k +: 2];
                if (p[c*3+k]) begin
                    if (fv == 2'b01) csat = 1; else if (fv != 2'b00) cfalse = 0;
                end
                if (n[c*3+k]) begin
                    if (fv == 2'b00) csat = 1; else if (fv != 2'b01) cfalse = 0;
                end
            end
            if (!csat) begin
                all_sat = 0;
                if (cfalse) return 2'b00;
            end
        end
        return all_sat ? 2'b01 : 2'b10;
    endfunction

    assign eval_a = eval_fn(mode, cpos, cneg, ncl, asg_a);
    assign eval_b = eval_fn(mode, cpos, cneg, ncl, asg_b);

    dpll_search_ctrl #(.NUM_VARS(NV), .MAX_CYCLES(BIG)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .eval_result(eval_a), .assignment(asg_a),
        .busy(busy_a), .done(done_a), .sat(sat_a), .timeout(to_a), .decisions(dec_a)
    );

    dpll_search_ctrl #(.NUM_VARS(NV), .MAX_CYCLES(MAXB)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .eval_result(eval_b), .assignment(asg_b),
        .busy(busy_b), .done(done_b), .sat(sat_b), .timeout(to_b), .decisions(dec_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Depth-first search: each evaluation, decision and backtrack step is one cycle;
    // the cycle numbered maxc is consumed by the timeout instead of its own action.
    task automatic model_run(input int maxc, output int nst, output int first_bt,
                             output bit msat, output bit mto, output logic [5:0] masg,
                             output int mdec);
        logic [1:0] v[NV];
        int tried[NV];
        int depth, cyc;
        bit aborted, finished;
        logic [5:0] pk;
        logic [1:0] r;
        for (int k = 0; k < NV; k++) begin v[k] = 2'b10; tried[k] = 0; end
        depth = 0; cyc = 0; aborted = 0; finished = 0;
        first_bt = -1; msat = 0; mdec = 0;
        while (1) begin
            cyc++;
            if (cyc >= maxc) begin aborted = 1; break; end
            for (int k = 0; k < NV; k++) pk[2*k +: 2] = v[k];
            r = eval_fn(mode, cpos, cneg, ncl, pk);
            if (r == 2'b01) begin msat = 1; break; end
            if (r != 2'b00) begin
                cyc++;
                if (cyc >= maxc) begin aborted = 1; break; end
                if (depth < NV) begin
                    v[depth] = 2'b00; tried[depth] = 1; mdec++; depth++;
                    continue;
                end
            end
            while (1) begin
                cyc++;
                if (first_bt < 0) first_bt = cyc;
                if (cyc >= maxc) begin aborted = 1; break; end
                if (depth == 0) begin finished = 1; break; end
                if (tried[depth-1] == 1) begin
                    v[depth-1] = 2'b01; tried[depth-1] = 2; mdec++;
                    break;
                end
                v[depth-1] = 2'b10; tried[depth-1] = 0; depth--;
            end
            if (aborted || finished) break;
        end
        nst = cyc;
        mto = aborted;
        if (aborted) msat = 0;
        for (int k = 0; k < NV; k++) masg[2*k +: 2] = v[k];
    endtask

    // extra: 0 plain, 1 re-pulse start mid-search, 2 assert start during FINISH
    task automatic run_case(input int extra);
        int nst_a, fb_a, md_a, nst_b, fb_b, md_b, cyc;
        bit ms_a, mt_a, ms_b, mt_b, got_a, got_b;
        logic [5:0] ma_a, ma_b;
        model_run(BIG, nst_a, fb_a, ms_a, mt_a, ma_a, md_a);
        model_run(MAXB, nst_b, fb_b, ms_b, mt_b, ma_b, md_b);
        got_a = 0; got_b = 0; ta = -1; tb = -1;
        @(posedge clk); #1; start_a = 1; start_b = 1;
        @(posedge clk); #1; start_a = 0; start_b = 0;
        cyc = 1;
        while (cyc <= BUDGET && !(got_a && got_b && cyc > ta + 1 && cyc > tb + 1)) begin
            if (got_a && cyc == ta + 1) begin
                chk("a_done_pulse", done_a, 0);
                chk("a_sat_held", sat_a, ms_a);
                chk("a_idle_after", busy_a, 0);
                if (extra == 2) start_a = 0;
            end
            if (!got_a && done_a) begin
                got_a = 1; ta = cyc;
                cs_a = sat_a; ct_a = to_a; ca_a = asg_a; cd_a = dec_a;
                if (extra == 2) start_a = 1;
            end
            if (got_b && cyc == tb + 1) chk("b_done_pulse", done_b, 0);
            if (!got_b && done_b) begin
                got_b = 1; tb = cyc;
                cs_b = sat_b; ct_b = to_b; ca_b = asg_b; cd_b = dec_b;
            end
            if (extra == 1 && cyc == 2) start_a = 1;
            if (extra == 1 && cyc == 3) start_a = 0;
            @(posedge clk); #1; cyc++;
        end
        start_a = 0;
        chk("a_finished", got_a, 1);
        chk("b_finished", got_b, 1);
        chk("a_done_cyc", ta, nst_a + 1);
        chk("a_sat", cs_a, ms_a);
        chk("a_timeout", ct_a, mt_a);
        chk("a_asg", ca_a, ma_a);
        chk("a_dec", cd_a, md_a);
        chk("b_done_cyc", tb, nst_b + 1);
        chk("b_sat", cs_b, ms_b);
        chk("b_timeout", ct_b, mt_b);
        chk("b_asg", ca_b, ma_b);
        chk("b_dec", cd_b, md_b);
    endtask

    task automatic reset_abort;
        int nst, fb, md, cyc;
        bit ms, mt, saw_done;
        logic [5:0] ma;
        model_run(BIG, nst, fb, ms, mt, ma, md);
        @(posedge clk); #1; start_a = 1; start_b = 1;
        @(posedge clk); #1; start_a = 0; start_b = 0;
        cyc = 1;
        while (cyc < fb) begin @(posedge clk); #1; cyc++; end
        chk("rst_pre_busy", busy_a, 1);
        rst = 1;
        @(posedge clk); #1;
        chk("rst_busy", busy_a, 0);
        chk("rst_asg", asg_a, ALL_U);
        chk("rst_dec", dec_a, 0);
        chk("rst_done", done_a, 0);
        rst = 0;
        saw_done = 0;
        repeat (5) begin @(posedge clk); #1; if (done_a || busy_a) saw_done = 1; end
        chk("rst_no_done", saw_done, 0);
    endtask

    initial begin
        int sel;
        rst = 1; start_a = 0; start_b = 0;
        mode = 1; cpos = '0; cneg = '0; ncl = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy_a, 0);
        chk("reset_done", done_a, 0);
        chk("reset_sat", sat_a, 0);
        chk("reset_timeout", to_a, 0);
        chk("reset_asg", asg_a, ALL_U);
        chk("reset_dec", dec_a, 0);
        rst = 0;

        mode = 0; cpos = 12'b001; cneg = '0; ncl = 1;
        run_case(0);
        chk("x0_sat", cs_a, 1);
        chk("x0_asg", ca_a, 6'b101001);
        chk("x0_dec", cd_a, 2);
        run_case(1);
        chk("x0_restart_dec", cd_a, 2);
        chk("x0_restart_asg", ca_a, 6'b101001);

        mode = 1;
        run_case(2);
        chk("unsat_done_cyc", ta, 3);
        chk("unsat_dec", cd_a, 0);

        mode = 2;
        run_case(0);
        chk("full_dec", cd_a, 14);
        chk("full_asg", ca_a, ALL_U);
        chk("full_sat", cs_a, 0);
        chk("tiny_timeout", ct_b, 1);
        chk("tiny_sat", cs_b, 0);

        reset_abort();

        for (int r = 0; r < 24; r++) begin
            mode = 0; ncl = $urandom_range(1, 4); cpos = '0; cneg = '0;
            for (int c = 0; c < ncl; c++) begin
                for (int k = 0; k < NV; k++) begin
                    sel = $urandom_range(0, 2);
                    if (sel == 1) cpos[c*3+k] = 1'b1;
                    if (sel == 2) cneg[c*3+k] = 1'b1;
                end
                if (cpos[c*3 +: 3] == 3'b000 && cneg[c*3 +: 3] == 3'b000)
                    cpos[c*3 + $urandom_range(0, 2)] = 1'b1;
            end
            run_case($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/dpll_search_ctrl.md
DPLL_SEARCH_CTRL -- requirements
Module: dpll_search_ctrl

Interface
REQ-001 SHALL have parameter NUM_VARS, default 8: number of Boolean variables searched.
REQ-002 SHALL have parameter MAX_CYCLES, default 65535: search-cycle budget before timeout.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to begin a search; honoured only in IDLE.
REQ-006 SHALL have port eval_result, input, 2 bits: combinational verdict on the current assignment (00 UNSAT, 01 SAT, 10 UNKNOWN; 11 treated as UNKNOWN).
REQ-007 SHALL have port assignment, output, NUM_VARS*2 bits: registered per-variable value, var k at [2k+:2] (00 FALSE, 01 TRUE, 10 UNKNOWN).
REQ-008 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when the search terminates.
REQ-010 SHALL have port sat, output, 1 bit: final verdict; held from done until the next accepted start.
REQ-011 SHALL have port timeout, output, 1 bit: search aborted on budget; held like sat.
REQ-012 SHALL have port decisions, output, 32 bits: count of DECIDE plus flip events in the current search.

Function
REQ-013 SHALL implement states IDLE, EVAL, DECIDE, BACKTRACK, FINISH.
REQ-014 IDLE with start SHALL set all variables UNKNOWN, level=0, flipped[]=0, decisions=0, sat=0, timeout=0, cycle counter=0, and go to EVAL.
REQ-015 EVAL SHALL sample eval_result one cycle after assignment last changed: SAT goes to FINISH with sat=1; UNSAT goes to BACKTRACK; UNKNOWN goes to DECIDE.
REQ-016 DECIDE SHALL set var[level]=FALSE, flipped[level]=0, level+=1, decisions+=1, then go to EVAL.
REQ-017 DECIDE with level==NUM_VARS (UNKNOWN on a full assignment) SHALL be treated as UNSAT and go to BACKTRACK.
REQ-018 BACKTRACK with level==0 SHALL go to FINISH with sat=0.
REQ-019 BACKTRACK with flipped[level-1]==0 SHALL set var[level-1]=TRUE, flipped=1, decisions+=1, then go to EVAL.
REQ-020 BACKTRACK with flipped[level-1]==1 SHALL set var[level-1]=UNKNOWN, level-=1, and remain in BACKTRACK; each state costs one cycle.
REQ-021 The cycle counter SHALL increment every busy cycle; on reaching MAX_CYCLES outside FINISH, the block SHALL go to FINISH with timeout=1 and sat=0, and timeout SHALL take priority over a simultaneous SAT.
REQ-022 FINISH SHALL pulse done for one cycle, keep assignment unchanged (the satisfying model when sat=1), and return to IDLE.
REQ-023 start while busy SHALL be ignored; start in the FINISH cycle SHALL be ignored.
REQ-024 level SHALL be $clog2(NUM_VARS+1) bits; decisions SHALL saturate at 32'hFFFFFFFF.

Reset
REQ-025 rst SHALL force IDLE, all assignment fields=UNKNOWN, level=0, flipped=0, busy=0, done=0, sat=0, timeout=0, decisions=0, cycle counter=0.
REQ-026 rst SHALL take priority over start and all transitions, including mid-search; no done pulse SHALL follow a reset abort.

Structure
REQ-027 Value encodings (FALSE/TRUE/UNKNOWN), result encodings (UNSAT/SAT/UNKNOWN) and the state enum SHALL live in shared package sat_pkg, also used by the clause evaluator.
REQ-028 No sub-module SHALL be used; literal-to-clause mapping between assignment and eval_result remains a separate block outside this one.

Verification (NUM_VARS=3; bench models eval_result combinationally)
REQ-029 Model: clause (x0) [U->UNKNOWN, F->UNSAT, T->SAT] -> sequence EVAL,DECIDE,EVAL,BACKTRACK,EVAL,FINISH; done=1, sat=1, assignment=6'b10_10_01, decisions=2.
REQ-030 Model: always UNSAT -> EVAL, BACKTRACK, FINISH; done on 3rd cycle after start; sat=0, decisions=0.
REQ-031 Model: UNKNOWN until all assigned, then UNSAT -> all 8 leaves visited, sat=0, decisions=14, assignment all 10.
REQ-032 Same model with MAX_CYCLES=10 -> done with timeout=1, sat=0.
REQ-033 rst asserted during BACKTRACK of scenario REQ-031 -> next cycle busy=0, assignment=6'b10_10_10, no done pulse.
REQ-034 start re-pulsed while busy in scenario REQ-029 -> identical result and decisions=2.
